// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state type and default debounce length for debounce_switch_pair.
package debounce_pkg;
  typedef enum logic {STABLE, COUNTING} db_state_e;
  localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one switch path -- two-flop synchroniser, STABLE/COUNTING FSM and counter.
// Edge pulses exist only when DEBOUNCE_EDGE_EN is defined; otherwise rise/fall are tied to 0.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic sw_db,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);
  logic [1:0] sync_q;
  logic synced;
  logic [CW-1:0] cnt;
  db_state_e state;
  assign synced = sync_q[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], sw};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= STABLE;
      cnt   <= '0;
      sw_db <= 1'b0;
    end else begin
      case (state)
        STABLE:
          if (synced != sw_db) begin
            state <= COUNTING;
            cnt   <= CW'(1);
          end else cnt <= '0;
        COUNTING:
          if (synced == sw_db) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= STABLE;
            cnt   <= '0;
            sw_db <= synced;
          end else cnt <= cnt + 1'b1;
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
`ifdef DEBOUNCE_EDGE_EN
  logic upd;
  // Registered alongside sw_db so the pulse coincides with the new value
  assign upd = state == COUNTING && synced != sw_db && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= upd & synced;
      fall <= upd & ~synced;
    end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
endmodule

// File: rtl/debounce_switch_pair.sv
// debounce_switch_pair: two independent debounced switch channels feeding a downstream AND stage.
// Define DEBOUNCE_EDGE_EN to build the rise/fall pulse outputs; otherwise they are constant 0.
module debounce_switch_pair
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  output logic o_Switch_1,
  output logic o_Switch_2,
  output logic o_Rise_1,
  output logic o_Rise_2,
  output logic o_Fall_1,
  output logic o_Fall_2
);
  debounce_channel #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_ch1 (
    .clk(i_Clk), .rst_n(i_Rst_L), .sw(i_Switch_1),
    .sw_db(o_Switch_1), .rise(o_Rise_1), .fall(o_Fall_1)
  );
  debounce_channel #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_ch2 (
    .clk(i_Clk), .rst_n(i_Rst_L), .sw(i_Switch_2),
    .sw_db(o_Switch_2), .rise(o_Rise_2), .fall(o_Fall_2)
  );
endmodule

// File: tb/tb_debounce_switch_pair.sv
// tb_debounce_switch_pair: directed table-driven check of debounce_switch_pair with DEBOUNCE_LIMIT = 4.
// Expected pulse bits follow DEBOUNCE_EDGE_EN, so the same bench covers both builds.
module tb_debounce_switch_pair;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, sw1 = 1'b0, sw2 = 1'b0;
  logic o1, o2, r1, r2, f1, f2;
  int vectors = 0, errors = 0;
  typedef struct {
    logic s1, s2;
    int reps;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];
  debounce_switch_pair #(.DEBOUNCE_LIMIT(4)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch_1(sw1), .i_Switch_2(sw2),
    .o_Switch_1(o1), .o_Switch_2(o2), .o_Rise_1(r1), .o_Rise_2(r2),
    .o_Fall_1(f1), .o_Fall_2(f2)
  );
  always #5 clk = ~clk;
  // Expected bits packed as {o1, o2, r1, r2, f1, f2}
  function automatic logic [5:0] ex(logic a, logic b, logic c, logic d, logic e, logic f);
    return {a, b, c, d, e, f};
  endfunction
  task automatic check(input string name, input logic [5:0] req);
    logic [5:0] act;
    act = {o1, o2, r1, r2, f1, f2};
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got {o1,o2,r1,r2,f1,f2}=%b expected %b at %0t", name, act, req, $time);
    end
  endtask
  task automatic add(input logic s1, input logic s2, input int reps, input logic [5:0] e);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.reps = reps; v.exp = e;
    tbl.push_back(v);
  endtask
  initial begin
    // Clean rise/fall on switch 1, channel 2 untouched
    add(1, 0, 5, ex(0, 0, 0, 0, 0, 0));
    add(1, 0, 1, ex(1, 0, E, 0, 0, 0));
    add(1, 0, 3, ex(1, 0, 0, 0, 0, 0));
    add(0, 0, 5, ex(1, 0, 0, 0, 0, 0));
    add(0, 0, 1, ex(0, 0, 0, 0, E, 0));
    add(0, 0, 3, ex(0, 0, 0, 0, 0, 0));
    // Switch 2 bounce of 3 cycles: nothing happens
    add(0, 1, 3, ex(0, 0, 0, 0, 0, 0));
    add(0, 0, 8, ex(0, 0, 0, 0, 0, 0));
    // Both switches together, AND stage sees both high on the same edge
    add(1, 1, 5, ex(0, 0, 0, 0, 0, 0));
    add(1, 1, 1, ex(1, 1, E, E, 0, 0));
    add(1, 1, 3, ex(1, 1, 0, 0, 0, 0));
    add(0, 1, 5, ex(1, 1, 0, 0, 0, 0));
    add(0, 1, 1, ex(0, 1, 0, 0, E, 0));
    add(0, 1, 3, ex(0, 1, 0, 0, 0, 0));
    add(0, 0, 5, ex(0, 1, 0, 0, 0, 0));
    add(0, 0, 1, ex(0, 0, 0, 0, 0, E));
    add(0, 0, 2, ex(0, 0, 0, 0, 0, 0));
    // Short bounce then hold: count restarts from the later edge
    add(1, 0, 2, ex(0, 0, 0, 0, 0, 0));
    add(0, 0, 1, ex(0, 0, 0, 0, 0, 0));
    add(1, 0, 5, ex(0, 0, 0, 0, 0, 0));
    add(1, 0, 1, ex(1, 0, E, 0, 0, 0));
    add(1, 0, 2, ex(1, 0, 0, 0, 0, 0));
    add(0, 0, 5, ex(1, 0, 0, 0, 0, 0));
    add(0, 0, 1, ex(0, 0, 0, 0, E, 0));
    add(0, 0, 2, ex(0, 0, 0, 0, 0, 0));

    // Reset held: toggling switches has no effect
    for (int i = 0; i < 20; i++) begin
      sw1 = i[0]; sw2 = ~i[0];
      @(posedge clk); #1;
      check("reset_hold", ex(0, 0, 0, 0, 0, 0));
    end
    sw1 = 0; sw2 = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle", ex(0, 0, 0, 0, 0, 0));
    end
    foreach (tbl[k])
      for (int j = 0; j < tbl[k].reps; j++) begin
        sw1 = tbl[k].s1; sw2 = tbl[k].s2;
        @(posedge clk); #1;
        check($sformatf("tbl[%0d]", k), tbl[k].exp);
      end

    // Reset after 2 counting cycles discards the count; switch held through release
    sw1 = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("pre_reset_count", ex(0, 0, 0, 0, 0, 0));
    end
    rst_n = 1'b0; #1;
    check("reset_midcount", ex(0, 0, 0, 0, 0, 0));
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_edge%0d", i), i == 6 ? ex(1, 0, E, 0, 0, 0) : ex(0, 0, 0, 0, 0, 0));
    end
    @(posedge clk); #1;
    check("post_reset_hold", ex(1, 0, 0, 0, 0, 0));
    // Asynchronous clear of a high output without a clock edge
    #2 rst_n = 1'b0; #1;
    check("async_clear", ex(0, 0, 0, 0, 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
